// File: rtl/lcd_spi_burst_master.sv
// lcd_spi_burst_master
// 4-wire (CSX/DC/SCK/SDA) SPI master for the LCD panel. One CSX-low burst carries a
// command byte (DC=0) followed by an optional stream of 1..MAX_WORD_BITS-bit data
// words (DC=1) taken over a valid/ready handshake. SCK is CPOL=0/CPHA=0 and only
// toggles while bits shift; a late upstream word parks the bus with SCK low.
//
// Optional build macro: LCD_SPI_READ_EN
//   When defined, the command handshake also samples rd_req. A read burst releases
//   SDA to 1 after the command byte, clocks one dummy bit, then shifts in the
//   effective data_bits (sampled with the command) from LCD_SDI, MSB first.
//   rd_valid pulses for one cycle as CS_HOLD is entered; rd_data holds the result.
module lcd_spi_burst_master #(
    parameter int CLK_DIV       = 2,   // system clocks per SCK half-period (>=1)
    parameter int MAX_WORD_BITS = 16,  // widest data word (8..32)
    parameter int CS_IDLE_HP    = 1    // half-periods CSX stays high between bursts (>=1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [7:0]                         cmd_byte,
    input  logic                               cmd_has_data,
    input  logic                               data_valid,
    output logic                               data_ready,
    input  logic [MAX_WORD_BITS-1:0]           data_word,
    input  logic [$clog2(MAX_WORD_BITS+1)-1:0] data_bits,
    input  logic                               data_last,
    input  logic                               abort,
`ifdef LCD_SPI_READ_EN
    input  logic                               rd_req,
    input  logic                               LCD_SDI,
    output logic [MAX_WORD_BITS-1:0]           rd_data,
    output logic                               rd_valid,
`endif
    output logic                               LCD_CSX,
    output logic                               LCD_DC,
    output logic                               LCD_SCK,
    output logic                               LCD_SDA,
    output logic                               busy
);

    localparam int BW    = $clog2(MAX_WORD_BITS + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HP_W  = (CS_IDLE_HP > 1) ? $clog2(CS_IDLE_HP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_LOAD,
        S_CS_HOLD,
        S_CS_IDLE
    } state_t;

    state_t                   state_q, state_d;
    logic [DIV_W-1:0]         div_q, div_d;     // half-period divider
    logic [HP_W-1:0]          hp_q, hp_d;       // CS_IDLE half-period counter
    logic [BW-1:0]            bit_q, bit_d;     // index of the bit on the wire
    logic [MAX_WORD_BITS-1:0] sh_q, sh_d;       // word being shifted (right-justified)
    logic                     last_q, last_d;   // current word closes the burst
    logic                     csx_q, csx_d;
    logic                     dc_q, dc_d;
    logic                     sck_q, sck_d;
    logic                     sda_q, sda_d;

`ifdef LCD_SPI_READ_EN
    logic                     rd_q, rd_d;             // burst is a read
    logic                     rd_phase_q, rd_phase_d; // dummy + read bits in progress
    logic [BW-1:0]            rd_len_q, rd_len_d;     // effective read width
    logic [MAX_WORD_BITS-1:0] rd_sh_q, rd_sh_d;       // read shift register
    logic                     rd_valid_q, rd_valid_d;
`endif

    logic                     tick;       // last clock of a half-period
    logic                     abort_hit;  // abort honoured this cycle
    logic [BW-1:0]            data_eff;   // effective width of the offered word
    logic [BW-1:0]            nxt_idx;    // index of the following bit
    logic [MAX_WORD_BITS-1:0] load_shift;
    logic [MAX_WORD_BITS-1:0] nxt_shift;

    // Width 0 or anything wider than the datapath means a full-width word.
    always_comb begin
        data_eff = data_bits;
        if (data_bits == '0 || data_bits > BW'(MAX_WORD_BITS)) begin
            data_eff = BW'(MAX_WORD_BITS);
        end
    end

    // Bit selection through shifts keeps the index width independent of the word width.
    always_comb begin
        nxt_idx    = bit_q - BW'(1);
        load_shift = data_word >> (data_eff - BW'(1));
        nxt_shift  = sh_q >> nxt_idx;
    end

    assign tick      = (state_q != S_IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
    assign abort_hit = abort && (state_q != S_IDLE);

    // Next-state, pin and handshake logic; abort overrides everything at the end.
    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        last_d     = last_q;
        csx_d      = csx_q;
        dc_d       = dc_q;
        sck_d      = sck_q;
        sda_d      = sda_q;
        data_ready = 1'b0;
`ifdef LCD_SPI_READ_EN
        rd_d       = rd_q;
        rd_phase_d = rd_phase_q;
        rd_len_d   = rd_len_q;
        rd_sh_d    = rd_sh_q;
        rd_valid_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_CS_SETUP;
                    sh_d    = MAX_WORD_BITS'(cmd_byte);
                    bit_d   = BW'(7);
                    last_d  = !cmd_has_data;
                    csx_d   = 1'b0;
                    dc_d    = 1'b0;
                    sck_d   = 1'b0;
                    sda_d   = cmd_byte[7];
`ifdef LCD_SPI_READ_EN
                    rd_d       = rd_req;
                    rd_phase_d = 1'b0;
                    rd_len_d   = data_eff;
                    rd_sh_d    = '0;
`endif
                end
            end

            S_CS_SETUP: begin
                if (tick) begin
                    state_d = S_SHIFT;
                    sck_d   = 1'b1;
                end
            end

            S_SHIFT: begin
                if (tick) begin
                    if (sck_q) begin
                        // End of high half: fall, present the following bit.
                        sck_d = 1'b0;
`ifdef LCD_SPI_READ_EN
                        if (bit_q != '0 && !rd_phase_q) begin
                            sda_d = nxt_shift[0];
                        end
`else
                        if (bit_q != '0) begin
                            sda_d = nxt_shift[0];
                        end
`endif
                    end else if (bit_q != '0) begin
                        // End of low half with bits remaining: rise into the next bit.
                        sck_d = 1'b1;
                        bit_d = nxt_idx;
`ifdef LCD_SPI_READ_EN
                        if (rd_phase_q) begin
                            rd_sh_d = {rd_sh_q[MAX_WORD_BITS-2:0], LCD_SDI};
                        end
`endif
                    end else begin
                        // End of the word's last low half.
`ifdef LCD_SPI_READ_EN
                        if (rd_q && !rd_phase_q) begin
                            rd_phase_d = 1'b1;
                            bit_d      = rd_len_q;
                            sda_d      = 1'b1;
                            sck_d      = 1'b1;
                        end else if (last_q || rd_phase_q) begin
                            state_d    = S_CS_HOLD;
                            rd_valid_d = rd_phase_q;
                        end else begin
                            state_d = S_LOAD;
                        end
`else
                        if (last_q) begin
                            state_d = S_CS_HOLD;
                        end else begin
                            state_d = S_LOAD;
                        end
`endif
                    end
                end
            end

            S_LOAD: begin
                if (data_valid) begin
                    data_ready = 1'b1;
                    state_d    = S_SHIFT;
                    sh_d       = data_word;
                    bit_d      = data_eff - BW'(1);
                    last_d     = data_last;
                    dc_d       = 1'b1;
                    sck_d      = 1'b1;
                    sda_d      = load_shift[0];
                end
            end

            S_CS_HOLD: begin
                if (tick) begin
                    state_d = S_CS_IDLE;
                    hp_d    = '0;
                    csx_d   = 1'b1;
                    dc_d    = 1'b1;
                    sda_d   = 1'b1;
                end
            end

            S_CS_IDLE: begin
                if (tick) begin
                    if (hp_q == HP_W'(CS_IDLE_HP - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        hp_d = hp_q + HP_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d    = S_CS_IDLE;
            hp_d       = '0;
            sck_d      = 1'b0;
            csx_d      = 1'b1;
            dc_d       = 1'b1;
            sda_d      = 1'b1;
            data_ready = 1'b0;
`ifdef LCD_SPI_READ_EN
            rd_phase_d = 1'b0;
            rd_valid_d = 1'b0;
`endif
        end
    end

    // Divider idles in IDLE and restarts on every state entry (abort included).
    always_comb begin
        if (state_q == S_IDLE || state_d != state_q || abort_hit || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // State and pin registers; reset returns the bus to its idle levels at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            hp_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            last_q  <= 1'b0;
            csx_q   <= 1'b1;
            dc_q    <= 1'b1;
            sck_q   <= 1'b0;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hp_q    <= hp_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            last_q  <= last_d;
            csx_q   <= csx_d;
            dc_q    <= dc_d;
            sck_q   <= sck_d;
            sda_q   <= sda_d;
        end
    end

`ifdef LCD_SPI_READ_EN
    // Read-path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= 1'b0;
            rd_phase_q <= 1'b0;
            rd_len_q   <= '0;
            rd_sh_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            rd_phase_q <= rd_phase_d;
            rd_len_q   <= rd_len_d;
            rd_sh_q    <= rd_sh_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_sh_q;
    assign rd_valid = rd_valid_q;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign LCD_CSX   = csx_q;
    assign LCD_DC    = dc_q;
    assign LCD_SCK   = sck_q;
    assign LCD_SDA   = sda_q;

endmodule

// File: tb/tb_lcd_spi_burst_master.sv
// Directed bench for lcd_spi_burst_master (CLK_DIV=2, MAX_WORD_BITS=16, CS_IDLE_HP=1).
// A table of bursts with hand-computed bit streams and timings, plus hand-written
// sequences for abort, abort-in-IDLE and mid-word reset.
module tb_lcd_spi_burst_master;

    localparam int CLK_DIV = 2;
    localparam int MAXW    = 16;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_byte;
    logic        cmd_has_data;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] data_word;
    logic [4:0]  data_bits;
    logic        data_last;
    logic        abort;
    logic        LCD_CSX;
    logic        LCD_DC;
    logic        LCD_SCK;
    logic        LCD_SDA;
    logic        busy;
`ifdef LCD_SPI_READ_EN
    logic        rd_req;
    logic        LCD_SDI;
    logic [15:0] rd_data;
    logic        rd_valid;
`endif

    lcd_spi_burst_master #(
        .CLK_DIV       (CLK_DIV),
        .MAX_WORD_BITS (MAXW),
        .CS_IDLE_HP    (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_byte     (cmd_byte),
        .cmd_has_data (cmd_has_data),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_word    (data_word),
        .data_bits    (data_bits),
        .data_last    (data_last),
        .abort        (abort),
`ifdef LCD_SPI_READ_EN
        .rd_req       (rd_req),
        .LCD_SDI      (LCD_SDI),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
`endif
        .LCD_CSX      (LCD_CSX),
        .LCD_DC       (LCD_DC),
        .LCD_SCK      (LCD_SCK),
        .LCD_SDA      (LCD_SDA),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0]       cmd;
        logic             has_data;
        logic [1:0]       nwords;
        logic [2:0][15:0] words;
        logic [2:0][4:0]  bits;
        logic [7:0]       stall;
        logic [15:0]      exp_csx;
        logic [7:0]       exp_rises;
        logic [63:0]      exp_stream;
        logic [63:0]      exp_dc;
        logic [3:0]       exp_readies;
        logic [3:0]       exp_lag;
    } vec_t;

    vec_t tbl [5];

    int errors = 0;
    int checks = 0;

    // bus monitor state
    bit          mon_en = 1'b0;
    int          csx_low, csx_falls, rises, readies, cyc, csx_rise_t, busy_fall_t;
    logic [63:0] cap_sda, cap_dc;
    logic        prev_csx = 1'b1;
    logic        prev_sck = 1'b0;
    logic        prev_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic vec_t mk(input logic [7:0] cmd, input logic hd, input logic [1:0] n,
                                input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                                input logic [4:0] b0, input logic [4:0] b1, input logic [4:0] b2,
                                input logic [7:0] stall, input logic [15:0] csx,
                                input logic [7:0] rs, input logic [63:0] stream,
                                input logic [63:0] dc, input logic [3:0] rdy);
        vec_t v;
        v.cmd = cmd;  v.has_data = hd;  v.nwords = n;
        v.words[0] = w0;  v.words[1] = w1;  v.words[2] = w2;
        v.bits[0] = b0;   v.bits[1] = b1;   v.bits[2] = b2;
        v.stall = stall;  v.exp_csx = csx;  v.exp_rises = rs;
        v.exp_stream = stream;  v.exp_dc = dc;  v.exp_readies = rdy;
        v.exp_lag = 4'd2;
        return v;
    endfunction

    task automatic mon_clear();
        csx_low = 0; csx_falls = 0; rises = 0; readies = 0;
        csx_rise_t = -1; busy_fall_t = -1;
        cap_sda = '0; cap_dc = '0;
    endtask

    // Samples the pins on every falling clock edge.
    initial begin
        cyc = 0;
        mon_clear();
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!LCD_CSX) csx_low++;
                if (prev_csx && !LCD_CSX) csx_falls++;
                if (!prev_csx && LCD_CSX) csx_rise_t = cyc;
                if (prev_busy && !busy) busy_fall_t = cyc;
                if (!prev_sck && LCD_SCK) begin
                    rises++;
                    cap_sda = {cap_sda[62:0], LCD_SDA};
                    cap_dc  = {cap_dc[62:0], LCD_DC};
                end
                if (data_ready) readies++;
            end
            prev_csx  = LCD_CSX;
            prev_sck  = LCD_SCK;
            prev_busy = busy;
            cyc++;
        end
    end

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        if (busy) timeout_fail(name);
        @(negedge clk); #1;
    endtask

    task automatic wait_rises(input int n, input string name);
        int t;
        t = 0;
        while (rises < n && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        if (rises < n) timeout_fail(name);
    endtask

    task automatic run_entry(input int e);
        vec_t v;
        int   t;
        v = tbl[e];
        mon_clear();
        mon_en = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_byte = v.cmd; cmd_has_data = v.has_data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < int'(v.nwords); k++) begin
            data_valid = 1'b1;
            data_word  = v.words[k];
            data_bits  = v.bits[k];
            data_last  = (k == int'(v.nwords) - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!data_ready && t < 2000);
            if (!data_ready) timeout_fail("data_ready");
            @(posedge clk); #1;
            data_valid = 1'b0;
            if (k == 0 && v.stall != 0) begin
                repeat (2 * CLK_DIV * MAXW + int'(v.stall)) @(posedge clk);
                #1;
            end
        end
        data_valid = 1'b0;
        wait_idle("burst_idle");
        mon_en = 1'b0;
        check($sformatf("csx_low[%0d]", e), 64'(csx_low), 64'(v.exp_csx));
        check($sformatf("csx_falls[%0d]", e), 64'(csx_falls), 64'd1);
        check($sformatf("sck_rises[%0d]", e), 64'(rises), 64'(v.exp_rises));
        check($sformatf("sda_stream[%0d]", e), cap_sda, v.exp_stream);
        check($sformatf("dc_stream[%0d]", e), cap_dc, v.exp_dc);
        check($sformatf("data_ready_pulses[%0d]", e), 64'(readies), 64'(v.exp_readies));
        check($sformatf("busy_lag[%0d]", e), 64'(busy_fall_t - csx_rise_t), 64'(v.exp_lag));
        $display("burst %0d: cmd=%02h words=%0d csx_low=%0d rises=%0d stream=%0h readies=%0d",
                 e, v.cmd, v.nwords, csx_low, rises, cap_sda, readies);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_csx"}, 64'(LCD_CSX), 64'd1);
        check({tag, "_dc"}, 64'(LCD_DC), 64'd1);
        check({tag, "_sck"}, 64'(LCD_SCK), 64'd0);
        check({tag, "_sda"}, 64'(LCD_SDA), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_data_ready"}, 64'(data_ready), 64'd0);
    endtask

    initial begin
        tbl[0] = mk(8'h2A, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 5'd0, 5'd0, 5'd0,
                    8'd0, 16'd36, 8'd8, 64'h2A, 64'h0, 4'd0);
        tbl[1] = mk(8'h2C, 1'b1, 2'd3, 16'hF800, 16'h07E0, 16'h001F, 5'd16, 5'd16, 5'd16,
                    8'd0, 16'd231, 8'd56, 64'h2C_F800_07E0_001F, 64'h00_FFFF_FFFF_FFFF, 4'd3);
        tbl[2] = mk(8'h2C, 1'b1, 2'd3, 16'hF800, 16'h07E0, 16'h001F, 5'd16, 5'd16, 5'd16,
                    8'd20, 16'd251, 8'd56, 64'h2C_F800_07E0_001F, 64'h00_FFFF_FFFF_FFFF, 4'd3);
        tbl[3] = mk(8'h3C, 1'b1, 2'd1, 16'h8001, 16'h0000, 16'h0000, 5'd0, 5'd0, 5'd0,
                    8'd0, 16'd101, 8'd24, 64'h3C8001, 64'h00FFFF, 4'd1);
        tbl[4] = mk(8'hB1, 1'b1, 2'd2, 16'hFFF3, 16'hA5C3, 16'h0000, 5'd5, 5'd20, 5'd0,
                    8'd0, 16'd122, 8'd29, 64'h1633A5C3, 64'h1FFFFF, 4'd2);

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_byte = '0; cmd_has_data = 1'b0;
        data_valid = 1'b0; data_word = '0; data_bits = '0; data_last = 1'b0;
        abort = 1'b0;
`ifdef LCD_SPI_READ_EN
        rd_req = 1'b0; LCD_SDI = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset_pins("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int e = 0; e < 5; e++) begin
            run_entry(e);
        end

        // Abort on the 5th rising SCK edge of a command-only burst.
        mon_clear();
        mon_en = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_byte = 8'h2A; cmd_has_data = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rises(5, "abort_rises");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk); #1;
        check("abort_csx", 64'(LCD_CSX), 64'd1);
        check("abort_sck", 64'(LCD_SCK), 64'd0);
        check("abort_dc", 64'(LCD_DC), 64'd1);
        check("abort_sda", 64'(LCD_SDA), 64'd1);
        check("abort_busy", 64'(busy), 64'd1);
        @(negedge clk); #1;
        check("abort_cmd_ready_early", 64'(cmd_ready), 64'd0);
        @(negedge clk); #1;
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        mon_en = 1'b0;
        check("abort_rises", 64'(rises), 64'd5);
        check("abort_stream", cap_sda, 64'b00101);
        $display("abort: rises=%0d stream=%0h cmd_ready=%0d", rises, cap_sda, cmd_ready);

        // Abort together with a command in IDLE is ignored: the command is accepted.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_byte = 8'hA5; cmd_has_data = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; abort = 1'b0;
        @(negedge clk); #1;
        check("idle_abort_busy", 64'(busy), 64'd1);
        check("idle_abort_csx", 64'(LCD_CSX), 64'd0);
        check("idle_abort_dc", 64'(LCD_DC), 64'd0);
        check("idle_abort_sda", 64'(LCD_SDA), 64'd1);
        wait_idle("idle_abort_idle");
        $display("idle abort: command 0xA5 accepted, busy=%0d", busy);

        // Reset mid-word, then a normal burst.
        mon_clear();
        mon_en = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_byte = 8'h2C; cmd_has_data = 1'b1;
        data_valid = 1'b1; data_word = 16'hF800; data_bits = 5'd16; data_last = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rises(12, "reset_rises");
        rst_n = 1'b0;
        #1;
        check_reset_pins("midreset");
        mon_en = 1'b0;
        data_valid = 1'b0;
        $display("mid-word reset after %0d rises: csx=%0d sck=%0d busy=%0d", rises, LCD_CSX, LCD_SCK, busy);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_entry(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_spi_burst_master.md
Name: lcd_spi_burst_master

Overview:
Parametrised 4-wire (CSX/DC/SCK/SDA) SPI master for the LCD panel. It is the successor of the current fixed 8/16-bit LCD SPI driver. It accepts a command byte, then an optional stream of parameter or pixel words of 1..MAX_WORD_BITS bits over a valid/ready handshake, all inside one CSX-low burst. SCK runs only while bits shift, and the block stalls cleanly when upstream data is late. It sits between the command sequencer / pixel FIFO and the panel pins.

Parameters:
CLK_DIV, 2, system clocks per SCK half-period (>=1)
MAX_WORD_BITS, 16, widest data word (8..32)
CS_IDLE_HP, 1, SCK half-periods CSX held high between bursts (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; transfer on cmd_valid&&cmd_ready
cmd_byte  in  8  command byte, sent MSB first with DC=0
cmd_has_data  in  1  data words follow the command in the same burst
data_valid  in  1  data word available
data_ready  out  1  one-cycle pulse when the word is taken
data_word  in  MAX_WORD_BITS  right-justified word
data_bits  in  $clog2(MAX_WORD_BITS+1)  bits to send; 0 or >MAX_WORD_BITS means MAX_WORD_BITS
data_last  in  1  final word of the burst
abort  in  1  synchronous burst abort
LCD_CSX  out  1  chip select, active low
LCD_DC  out  1  0 = command, 1 = data
LCD_SCK  out  1  SPI clock, CPOL=0, CPHA=0
LCD_SDA  out  1  MOSI
busy  out  1  high from accept until return to IDLE

Behaviour:
- Reset values (rst_n low, async): LCD_CSX=1, LCD_DC=1, LCD_SCK=0, LCD_SDA=1, busy=0, cmd_ready=1, data_ready=0. All counters are cleared and the state is IDLE.
- Reset mid-burst: pins go to their reset values immediately. The word in flight is lost.
- Half-period tick: the divider counts 0..CLK_DIV-1 and runs only outside IDLE. It restarts at 0 on every state entry.
- IDLE: on cmd_valid&&cmd_ready, latch cmd_byte and cmd_has_data. The next cycle: cmd_ready=0, busy=1, LCD_CSX=0, LCD_DC=0, LCD_SDA=cmd_byte[7]. Go to CS_SETUP.
- CS_SETUP: one half-period with SCK low. Go to SHIFT.
- SHIFT, per bit: the high half-period (SCK=1), then the low half-period (SCK=0). SDA updates to the next bit at the start of the low half. The panel samples SDA on the rising edge.
- End of the last bit's low half:
  - Command with cmd_has_data=0, or word with data_last=1: go to CS_HOLD.
  - Otherwise: go to LOAD.
- LOAD: SCK stays 0 and CSX stays 0.
  - While data_valid=0, wait indefinitely (stall).
  - When data_valid=1: pulse data_ready for 1 cycle, latch data_word, data_bits and data_last. Next cycle DC=1 and SDA=MSB of the effective width. Go to SHIFT.
- CS_HOLD: one half-period with CSX still low. Then CSX=1, SDA=1, DC=1. Go to CS_IDLE.
- CS_IDLE: CS_IDLE_HP half-periods. Then IDLE, with cmd_ready=1 and busy=0 on the same edge.
- CSX-low duration, no data: CLK_DIV*(2+2*8) clocks.
- DC stays constant for a whole word; it never toggles mid-word.
- abort, any non-IDLE state: next cycle SCK=0, CSX=1, DC=1, SDA=1. Go to CS_IDLE. A data_ready pulse is not issued in the abort cycle.
- abort in IDLE: ignored.
- abort and reset together: reset wins.

Optional Feature:
Macro LCD_SPI_READ_EN.
- Defined: adds inputs rd_req (1 bit, sampled with the command handshake) and LCD_SDI (1), and outputs rd_data (MAX_WORD_BITS) and rd_valid (1).
- Read burst behaviour: after the command byte, SDA is released to 1 and one dummy bit is clocked. Then data_bits(effective, taken from the command-cycle data_bits) bits are sampled from LCD_SDI on SCK rising edges, shifted in MSB first.
- rd_valid pulses 1 cycle at CS_HOLD entry.
- Undefined: no read ports, and rd_req logic is absent.

Test Plan:
- CLK_DIV=2, cmd 0x2A, cmd_has_data=0 -> CSX low for exactly 36 clocks, 8 SCK rising edges, SDA bits 0,0,1,0,1,0,1,0, DC=0 throughout, busy falls 2 clocks after CSX rises.
- cmd 0x2C + 3 words 0xF800/0x07E0/0x001F (data_bits=16, last on the third) -> one CSX burst, 8+48 rising edges, DC=1 for the data words, 3 data_ready pulses.
- Same as the previous burst but data_valid withheld 20 clocks before the second word -> SCK held 0, CSX held 0 for 20 extra clocks, bit stream unchanged.
- data_bits=0 with MAX_WORD_BITS=16, word 0x8001 -> 16 bits sent, first and last bits 1.
- abort asserted at the 5th SCK edge -> next cycle CSX=1, SCK=0, then cmd_ready=1 after CS_IDLE_HP half-periods.
- rst_n pulled low mid-word -> all outputs at reset values in the same cycle. A new command after release completes normally.
